// File: rtl/reg_rename_file.sv
// ---------------------------------------------------------------------------
// reg_rename_file
//
// Architectural integer register file combined with the rename-tag table.
// Each of the REG_NUM registers holds its committed value, a busy bit and the
// ROB tag of its youngest in-flight producer. The issue stage reads two source
// operands per cycle (either a ready value or a pending producer tag). The ROB
// commit port retires values and clears busy bits. A misbranch flush drops all
// renaming.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   rdy                  global enable; all state holds while low
//   flush                misbranch flush from the ROB
//   issue_valid          an instruction is issuing this cycle
//   issue_rd             destination register of the issuing instruction
//   issue_has_rd         issuing instruction writes a register
//   issue_rob_num        ROB entry allocated to the issuing instruction
//   rs1_addr, rs2_addr   source register indices
//   rsX_busy             source is waiting on an in-flight producer
//   rsX_tag              producer ROB entry (meaningful when rsX_busy)
//   rsX_value            source value (meaningful when !rsX_busy)
//   commit_valid         ROB commit writing a register
//   commit_rd            committing destination register
//   commit_data          committing value
//   commit_rob_num       ROB entry being retired
//   retired_count        accepted commits since reset, wrapping
// ---------------------------------------------------------------------------
module reg_rename_file #(
    parameter int REG_NUM    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ROB_TAG_W  = 4,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,

    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_has_rd,
    input  logic [ROB_TAG_W-1:0]  issue_rob_num,

    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic [ROB_TAG_W-1:0]  rs1_tag,
    output logic [DATA_W-1:0]     rs1_value,
    output logic                  rs2_busy,
    output logic [ROB_TAG_W-1:0]  rs2_tag,
    output logic [DATA_W-1:0]     rs2_value,

    input  logic                  commit_valid,
    input  logic [REG_ADDR_W-1:0] commit_rd,
    input  logic [DATA_W-1:0]     commit_data,
    input  logic [ROB_TAG_W-1:0]  commit_rob_num,

    output logic [31:0]           retired_count
);

    // One source read result.
    typedef struct packed {
        logic                 busy;
        logic [ROB_TAG_W-1:0] tag;
        logic [DATA_W-1:0]    value;
    } src_read_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]    value_q [REG_NUM];
    logic [DATA_W-1:0]    value_d [REG_NUM];
    logic [ROB_TAG_W-1:0] tag_q   [REG_NUM];
    logic [ROB_TAG_W-1:0] tag_d   [REG_NUM];
    logic [REG_NUM-1:0]   busy_q;
    logic [REG_NUM-1:0]   busy_d;
    logic [31:0]          retired_count_q;
    logic [31:0]          retired_count_d;

    // ------------------------------------------------------------------
    // Decoded control
    // ------------------------------------------------------------------
    logic commit_wr;     // commit targets a real register
    logic commit_match;  // commit retires the youngest producer of commit_rd
    logic issue_wr;      // issue creates a new mapping this cycle

    assign commit_wr    = commit_valid && (commit_rd != '0);
    assign commit_match = commit_wr && busy_q[commit_rd] &&
                          (tag_q[commit_rd] == commit_rob_num);
    assign issue_wr     = issue_valid && issue_has_rd &&
                          (issue_rd != '0) && !flush;

    // ------------------------------------------------------------------
    // Source reads: combinational from pre-issue state, with a bypass from
    // the commit port when it is retiring exactly the producer being read.
    // A same-cycle issue is deliberately invisible here.
    // ------------------------------------------------------------------
    logic [REG_ADDR_W-1:0] src_addr [2];
    src_read_t             src_rd   [2];

    assign src_addr[0] = rs1_addr;
    assign src_addr[1] = rs2_addr;

    for (genvar p = 0; p < 2; p++) begin : g_src
        always_comb begin
            // NOTE: every field gets a default before the branches so this
            // block stays purely combinational with no inferred latch.
            src_rd[p] = '0;
            if (src_addr[p] != '0) begin
                src_rd[p].busy  = busy_q[src_addr[p]];
                src_rd[p].tag   = tag_q[src_addr[p]];
                src_rd[p].value = value_q[src_addr[p]];
                if (commit_match && (commit_rd == src_addr[p])) begin
                    src_rd[p].busy  = 1'b0;
                    src_rd[p].value = commit_data;
                end
            end
        end
    end

    assign rs1_busy  = src_rd[0].busy;
    assign rs1_tag   = src_rd[0].tag;
    assign rs1_value = src_rd[0].value;
    assign rs2_busy  = src_rd[1].busy;
    assign rs2_tag   = src_rd[1].tag;
    assign rs2_value = src_rd[1].value;

    assign retired_count = retired_count_q;

    // ------------------------------------------------------------------
    // Next-state logic
    //   Commit is applied first, then issue, so that an issue to the same
    //   register wins the mapping while commit still writes the value.
    //   Flush clears every busy bit and drops the issue, but the commit in
    //   the same cycle still lands (jalr commit coinciding with misbranch).
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: blocking assignments are correct in combinational logic; the
        // later statements below intentionally override the earlier ones.
        value_d         = value_q;
        tag_d           = tag_q;
        busy_d          = busy_q;
        retired_count_d = retired_count_q;

        if (commit_valid) begin
            retired_count_d = retired_count_q + 32'd1;
        end

        if (commit_wr) begin
            value_d[commit_rd] = commit_data;
        end

        // A tag mismatch means a younger producer owns the register: keep it.
        if (commit_match) begin
            busy_d[commit_rd] = 1'b0;
        end

        if (flush) begin
            busy_d = '0;
        end else if (issue_wr) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_rob_num;
        end

        // x0 is hardwired to zero and never renamed.
        value_d[0] = '0;
        tag_d[0]   = '0;
        busy_d[0]  = 1'b0;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this array is reset because architectural state must read
            // as zero after reset; that keeps it in flops rather than a RAM
            // macro, which is acceptable at 32 entries.
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q          <= '0;
            retired_count_q <= '0;
        end else if (rdy) begin
            // NOTE: non-blocking assignments for all sequential state so
            // every register samples the same pre-edge values.
            value_q         <= value_d;
            tag_q           <= tag_d;
            busy_q          <= busy_d;
            retired_count_q <= retired_count_d;
        end
    end

endmodule

// File: tb/tb_reg_rename_file.sv
// ---------------------------------------------------------------------------
// tb_reg_rename_file
//
// Directed scenarios for reset, x0, commit bypass, tag overwrite, same-cycle
// issue/commit, flush, rdy hold and mid-operation reset, followed by a long
// randomized run compared against a behavioural array model.
// ---------------------------------------------------------------------------
module tb_reg_rename_file;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_has_rd;
    logic [3:0]  issue_rob_num;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic [3:0]  rs1_tag;
    logic [31:0] rs1_value;
    logic        rs2_busy;
    logic [3:0]  rs2_tag;
    logic [31:0] rs2_value;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic [3:0]  commit_rob_num;
    logic [31:0] retired_count;

    int n_cmp = 0;
    int n_err = 0;

    reg_rename_file dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_has_rd   (issue_has_rd),
        .issue_rob_num  (issue_rob_num),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_busy       (rs1_busy),
        .rs1_tag        (rs1_tag),
        .rs1_value      (rs1_value),
        .rs2_busy       (rs2_busy),
        .rs2_tag        (rs2_tag),
        .rs2_value      (rs2_value),
        .commit_valid   (commit_valid),
        .commit_rd      (commit_rd),
        .commit_data    (commit_data),
        .commit_rob_num (commit_rob_num),
        .retired_count  (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // a further unit later, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush          = 1'b0;
        issue_valid    = 1'b0;
        issue_rd       = '0;
        issue_has_rd   = 1'b0;
        issue_rob_num  = '0;
        commit_valid   = 1'b0;
        commit_rd      = '0;
        commit_data    = '0;
        commit_rob_num = '0;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] tag);
        issue_valid   = 1'b1;
        issue_has_rd  = 1'b1;
        issue_rd      = rd;
        issue_rob_num = tag;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [31:0] data,
                             input logic [3:0] tag);
        commit_valid   = 1'b1;
        commit_rd      = rd;
        commit_data    = data;
        commit_rob_num = tag;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        idle();
        rdy = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rs1_addr = 5'd5;
        rs2_addr = 5'd31;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_x5_busy: got %0b want 0", rs1_busy);
        end
        n_cmp++;
        if (rs1_value !== 32'h0) begin
            n_err++; $display("FAIL reset_x5_value: got %h want 0", rs1_value);
        end
        n_cmp++;
        if (rs2_busy !== 1'b0 || rs2_value !== 32'h0) begin
            n_err++; $display("FAIL reset_x31: got busy %0b value %h want 0/0", rs2_busy, rs2_value);
        end
        n_cmp++;
        if (retired_count !== 32'd0) begin
            n_err++; $display("FAIL reset_count: got %0d want 0", retired_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_x0();
        rs1_addr = 5'd0;
        do_commit(5'd0, 32'hDEADBEEF, 4'd0);
        #1;
        n_cmp++;
        if (rs1_value !== 32'h0 || rs1_busy !== 1'b0) begin
            n_err++; $display("FAIL x0_bypass: got busy %0b value %h want 0/0", rs1_busy, rs1_value);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs1_value !== 32'h0 || rs1_busy !== 1'b0 || rs1_tag !== 4'd0) begin
            n_err++; $display("FAIL x0_read: got busy %0b tag %0d value %h want 0/0/0", rs1_busy, rs1_tag, rs1_value);
        end
        n_cmp++;
        if (retired_count !== 32'd1) begin
            n_err++; $display("FAIL x0_count: got %0d want 1", retired_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_bypass();
        do_issue(5'd3, 4'd4);
        tick();
        idle();
        rs1_addr = 5'd3;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd4) begin
            n_err++; $display("FAIL issue_map: got busy %0b tag %0d want 1/4", rs1_busy, rs1_tag);
        end
        do_commit(5'd3, 32'h11, 4'd4);
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0 || rs1_value !== 32'h11) begin
            n_err++; $display("FAIL commit_bypass: got busy %0b value %h want 0/00000011", rs1_busy, rs1_value);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0 || rs1_value !== 32'h11) begin
            n_err++; $display("FAIL commit_after: got busy %0b value %h want 0/00000011", rs1_busy, rs1_value);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_tag_overwrite();
        do_issue(5'd3, 4'd4);
        tick();
        do_issue(5'd3, 4'd7);
        tick();
        idle();
        rs2_addr = 5'd3;
        do_commit(5'd3, 32'h22, 4'd4);
        #1;
        // Older producer retiring: no bypass, register still owned by tag 7.
        n_cmp++;
        if (rs2_busy !== 1'b1 || rs2_tag !== 4'd7) begin
            n_err++; $display("FAIL stale_no_bypass: got busy %0b tag %0d want 1/7", rs2_busy, rs2_tag);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs2_busy !== 1'b1 || rs2_tag !== 4'd7 || rs2_value !== 32'h22) begin
            n_err++; $display("FAIL stale_commit: got busy %0b tag %0d value %h want 1/7/00000022", rs2_busy, rs2_tag, rs2_value);
        end
        do_commit(5'd3, 32'h33, 4'd7);
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs2_busy !== 1'b0 || rs2_value !== 32'h33) begin
            n_err++; $display("FAIL young_commit: got busy %0b value %h want 0/00000033", rs2_busy, rs2_value);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_same_cycle();
        rs1_addr = 5'd6;
        do_issue(5'd6, 4'd2);
        do_commit(5'd6, 32'h44, 4'd9);
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd2 || rs1_value !== 32'h44) begin
            n_err++; $display("FAIL same_cycle: got busy %0b tag %0d value %h want 1/2/00000044", rs1_busy, rs1_tag, rs1_value);
        end
        n_cmp++;
        if (retired_count !== 32'd5) begin
            n_err++; $display("FAIL same_cycle_count: got %0d want 5", retired_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        logic [4:0] regs [4];
        regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd9; regs[3] = 5'd6;
        do_issue(5'd1, 4'd1); tick();
        do_issue(5'd2, 4'd2); tick();
        do_issue(5'd9, 4'd3); tick();
        idle();
        rs1_addr = 5'd9;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd3) begin
            n_err++; $display("FAIL flush_pre: got busy %0b tag %0d want 1/3", rs1_busy, rs1_tag);
        end
        flush = 1'b1;
        do_issue(5'd10, 4'd5);
        do_commit(5'd1, 32'h55, 4'd1);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            rs1_addr = regs[i];
            #1;
            n_cmp++;
            if (rs1_busy !== 1'b0) begin
                n_err++; $display("FAIL flush_busy_x%0d: got %0b want 0", regs[i], rs1_busy);
            end
        end
        rs1_addr = 5'd1;
        rs2_addr = 5'd10;
        #1;
        n_cmp++;
        if (rs1_value !== 32'h55) begin
            n_err++; $display("FAIL flush_commit: got %h want 00000055", rs1_value);
        end
        n_cmp++;
        if (rs2_busy !== 1'b0) begin
            n_err++; $display("FAIL flush_issue_dropped: got busy %0b want 0", rs2_busy);
        end
        n_cmp++;
        if (retired_count !== 32'd6) begin
            n_err++; $display("FAIL flush_count: got %0d want 6", retired_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_rdy_hold();
        do_issue(5'd12, 4'd8);
        tick();
        idle();
        rdy = 1'b0;
        do_issue(5'd13, 4'd6);
        do_commit(5'd12, 32'hAA, 4'd8);
        tick(); tick(); tick();
        rs1_addr = 5'd12;
        rs2_addr = 5'd13;
        idle();
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd8 || rs1_value !== 32'h0) begin
            n_err++; $display("FAIL hold_x12: got busy %0b tag %0d value %h want 1/8/0", rs1_busy, rs1_tag, rs1_value);
        end
        n_cmp++;
        if (rs2_busy !== 1'b0) begin
            n_err++; $display("FAIL hold_x13: got busy %0b want 0", rs2_busy);
        end
        n_cmp++;
        if (retired_count !== 32'd6) begin
            n_err++; $display("FAIL hold_count: got %0d want 6", retired_count);
        end
        rdy = 1'b1;
        do_commit(5'd12, 32'hAA, 4'd8);
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0 || rs1_value !== 32'hAA || retired_count !== 32'd7) begin
            n_err++; $display("FAIL resume: got busy %0b value %h count %0d want 0/000000aa/7", rs1_busy, rs1_value, retired_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        do_commit(5'd4, 32'h77, 4'd0);
        tick();
        idle();
        do_issue(5'd4, 4'd11);
        tick();
        rst = 1'b1;
        do_issue(5'd4, 4'd12);
        do_commit(5'd4, 32'h99, 4'd11);
        tick();
        rst = 1'b0;
        idle();
        rs1_addr = 5'd4;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0 || rs1_value !== 32'h0 || retired_count !== 32'd0) begin
            n_err++; $display("FAIL reset_mid: got busy %0b value %h count %0d want 0/0/0", rs1_busy, rs1_value, retired_count);
        end
    endtask

    // ------------------------------------------------------------------
    // Random traffic against an array model of the register file.
    // ------------------------------------------------------------------
    task automatic test_random();
        logic [31:0] m_val  [32];
        logic        m_busy [32];
        logic [3:0]  m_tag  [32];
        logic [31:0] m_count;
        logic [4:0]  a;
        logic        e_busy;
        logic [3:0]  e_tag;
        logic [31:0] e_val;
        logic        g_busy;
        logic [3:0]  g_tag;
        logic [31:0] g_val;

        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 32; r++) begin
            m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
        end
        m_count = '0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            // Small register window so hazards and bypasses are frequent.
            rdy          = ($urandom_range(0, 9) != 0);
            flush        = ($urandom_range(0, 19) == 0);
            issue_valid  = $urandom_range(0, 1);
            issue_has_rd = ($urandom_range(0, 3) != 0);
            issue_rd     = 5'($urandom_range(0, 7));
            issue_rob_num = 4'($urandom);
            commit_valid = $urandom_range(0, 1);
            commit_rd    = 5'($urandom_range(0, 7));
            commit_data  = $urandom;
            commit_rob_num = ($urandom_range(0, 2) != 0) ? m_tag[commit_rd] : 4'($urandom);
            rs1_addr     = 5'($urandom_range(0, 8));
            rs2_addr     = 5'($urandom_range(0, 8));
            #1;

            for (int p = 0; p < 2; p++) begin
                a      = (p == 0) ? rs1_addr  : rs2_addr;
                g_busy = (p == 0) ? rs1_busy  : rs2_busy;
                g_tag  = (p == 0) ? rs1_tag   : rs2_tag;
                g_val  = (p == 0) ? rs1_value : rs2_value;
                if (a == 0) begin
                    e_busy = 1'b0; e_tag = '0; e_val = '0;
                end else if (commit_valid && commit_rd == a && m_busy[a] &&
                             m_tag[a] == commit_rob_num) begin
                    e_busy = 1'b0; e_tag = m_tag[a]; e_val = commit_data;
                end else begin
                    e_busy = m_busy[a]; e_tag = m_tag[a]; e_val = m_val[a];
                end
                n_cmp++;
                if (g_busy !== e_busy) begin
                    n_err++; $display("FAIL rand_busy cyc %0d rs%0d x%0d: got %0b want %0b", cyc, p + 1, a, g_busy, e_busy);
                end
                if (e_busy) begin
                    n_cmp++;
                    if (g_tag !== e_tag) begin
                        n_err++; $display("FAIL rand_tag cyc %0d rs%0d x%0d: got %0d want %0d", cyc, p + 1, a, g_tag, e_tag);
                    end
                end else begin
                    n_cmp++;
                    if (g_val !== e_val) begin
                        n_err++; $display("FAIL rand_value cyc %0d rs%0d x%0d: got %h want %h", cyc, p + 1, a, g_val, e_val);
                    end
                end
            end
            n_cmp++;
            if (retired_count !== m_count) begin
                n_err++; $display("FAIL rand_count cyc %0d: got %0d want %0d", cyc, retired_count, m_count);
            end

            @(posedge clk);
            if (rdy) begin
                if (commit_valid) begin
                    m_count = m_count + 1;
                    if (commit_rd != 0) begin
                        m_val[commit_rd] = commit_data;
                        if (m_busy[commit_rd] && m_tag[commit_rd] == commit_rob_num)
                            m_busy[commit_rd] = 1'b0;
                    end
                end
                if (flush) begin
                    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
                end else if (issue_valid && issue_has_rd && issue_rd != 0) begin
                    m_busy[issue_rd] = 1'b1;
                    m_tag[issue_rd]  = issue_rob_num;
                end
            end
            #1;
        end
        idle();
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst      = 1'b1;
        rdy      = 1'b1;
        rs1_addr = '0;
        rs2_addr = '0;
        idle();
        test_reset();
        test_x0();
        test_bypass();
        test_tag_overwrite();
        test_same_cycle();
        test_flush();
        test_rdy_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
